// File: rtl/armleocpu_tlb_ctrl_if.sv
// Command/response and per-way bus between the MMU/fetch logic, the TLB controller and its ways.
// The slave modport is the controller's view; the master modport is the surrounding logic's view.
interface armleocpu_tlb_ctrl_if #(
   parameter int WAYS   = 2,
   parameter int PHYS_W = 22,
   parameter int CNT_W  = 16
);
   logic                     cmd_ready;
   logic                     cmd_resolve;
   logic                     cmd_write;
   logic                     cmd_invalidate;
   logic [19:0]              cmd_vaddr;
   logic                     cmd_enable;
   logic [7:0]               cmd_accesstag;
   logic [PHYS_W-1:0]        cmd_phys;

   logic                     resp_valid;
   logic                     resp_miss;
   logic                     resp_multihit;
   logic [7:0]               resp_accesstag;
   logic [PHYS_W-1:0]        resp_phys;

   logic [WAYS-1:0]          way_resolve;
   logic [WAYS-1:0]          way_write;
   logic [WAYS-1:0]          way_invalidate;
   logic [19:0]              way_vaddr;
   logic                     way_enable;
   logic [19:0]              way_vaddr_w;
   logic [7:0]               way_accesstag_w;
   logic [PHYS_W-1:0]        way_phys_w;
   logic [WAYS-1:0]          way_done;
   logic [WAYS-1:0]          way_miss;
   logic [8*WAYS-1:0]        way_accesstag_r;
   logic [PHYS_W*WAYS-1:0]   way_phys_r;

   logic [CNT_W-1:0]         hit_count;
   logic [CNT_W-1:0]         miss_count;

   modport slave (
      input  cmd_resolve, cmd_write, cmd_invalidate, cmd_vaddr, cmd_enable,
             cmd_accesstag, cmd_phys,
             way_done, way_miss, way_accesstag_r, way_phys_r,
      output cmd_ready, resp_valid, resp_miss, resp_multihit, resp_accesstag, resp_phys,
             way_resolve, way_write, way_invalidate, way_vaddr, way_enable,
             way_vaddr_w, way_accesstag_w, way_phys_w, hit_count, miss_count
   );

   modport master (
      output cmd_resolve, cmd_write, cmd_invalidate, cmd_vaddr, cmd_enable,
             cmd_accesstag, cmd_phys,
             way_done, way_miss, way_accesstag_r, way_phys_r,
      input  cmd_ready, resp_valid, resp_miss, resp_multihit, resp_accesstag, resp_phys,
             way_resolve, way_write, way_invalidate, way_vaddr, way_enable,
             way_vaddr_w, way_accesstag_w, way_phys_w, hit_count, miss_count
   );
endinterface

// File: rtl/armleocpu_tlb_ctrl.sv
// TLB way sequencer: broadcasts resolve/refill/invalidate to all ways, merges the per-way
// results into one response, picks refill victims round-robin and counts hits and misses.
module armleocpu_tlb_ctrl #(
   parameter int WAYS   = 2,
   parameter int PHYS_W = 22,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   armleocpu_tlb_ctrl_if.slave    ctrl_bus
);
   localparam int WAYS_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_INV, OP_WRITE, OP_RESOLVE} op_t;

   state_t              state_q, state_d;
   op_t                 op_q, op_d;
   logic [WAYS_W-1:0]   victim_q, victim_d;
   logic [WAYS-1:0]     way_resolve_q, way_resolve_d;
   logic [WAYS-1:0]     way_write_q, way_write_d;
   logic [WAYS-1:0]     way_inv_q, way_inv_d;
   logic [19:0]         way_vaddr_q, way_vaddr_d;
   logic                way_enable_q, way_enable_d;
   logic [19:0]         vaddr_w_q, vaddr_w_d;
   logic [7:0]          tag_w_q, tag_w_d;
   logic [PHYS_W-1:0]   phys_w_q, phys_w_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_miss_q, resp_miss_d;
   logic                resp_multi_q, resp_multi_d;
   logic [7:0]          resp_tag_q, resp_tag_d;
   logic [PHYS_W-1:0]   resp_phys_q, resp_phys_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

   // Merge of the per-way results; a way that has not finished forces a miss.
   logic [WAYS-1:0]     hit;
   logic [WAYS_W:0]     n_hits;
   logic [7:0]          sel_tag;
   logic [PHYS_W-1:0]   sel_phys;
   logic                merged_miss;
   logic                merged_multi;

   always_comb begin
      hit      = ctrl_bus.way_done & ~ctrl_bus.way_miss;
      n_hits   = '0;
      sel_tag  = '0;
      sel_phys = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         n_hits = n_hits + (WAYS_W + 1)'(hit[i]);
         if (hit[i]) begin
            sel_tag  = ctrl_bus.way_accesstag_r[8*i +: 8];
            sel_phys = ctrl_bus.way_phys_r[PHYS_W*i +: PHYS_W];
         end
      end
      merged_miss  = ~(&ctrl_bus.way_done) | ~(|hit);
      merged_multi = way_enable_q & (n_hits > (WAYS_W + 1)'(1));
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      victim_d      = victim_q;
      way_resolve_d = '0;
      way_write_d   = '0;
      way_inv_d     = '0;
      way_vaddr_d   = way_vaddr_q;
      way_enable_d  = way_enable_q;
      vaddr_w_d     = vaddr_w_q;
      tag_w_d       = tag_w_q;
      phys_w_d      = phys_w_q;
      resp_valid_d  = 1'b0;
      resp_miss_d   = resp_miss_q;
      resp_multi_d  = resp_multi_q;
      resp_tag_d    = resp_tag_q;
      resp_phys_d   = resp_phys_q;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_bus.cmd_invalidate) begin
               op_d      = OP_INV;
               way_inv_d = '1;
               state_d   = ST_ISSUE;
            end else if (ctrl_bus.cmd_write) begin
               op_d        = OP_WRITE;
               way_write_d = WAYS'(1) << victim_q;
               vaddr_w_d   = ctrl_bus.cmd_vaddr;
               tag_w_d     = ctrl_bus.cmd_accesstag;
               phys_w_d    = ctrl_bus.cmd_phys;
               state_d     = ST_ISSUE;
            end else if (ctrl_bus.cmd_resolve) begin
               op_d          = OP_RESOLVE;
               way_resolve_d = '1;
               way_vaddr_d   = ctrl_bus.cmd_vaddr;
               way_enable_d  = ctrl_bus.cmd_enable;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_IDLE;
            case (op_q)
               OP_INV:     victim_d = '0;
               // Victim advances even for an invalid refill entry.
               OP_WRITE:   victim_d = (victim_q == WAYS_W'(WAYS - 1)) ? '0 : victim_q + 1'b1;
               OP_RESOLVE: state_d  = ST_WAIT;
               default:    state_d  = ST_IDLE;
            endcase
         end
         ST_WAIT: begin
            resp_valid_d = 1'b1;
            resp_miss_d  = merged_miss;
            resp_multi_d = merged_multi;
            resp_tag_d   = merged_miss ? 8'h00 : sel_tag;
            resp_phys_d  = merged_miss ? '0 : sel_phys;
            if (merged_miss) begin
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end else begin
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_NONE;
         victim_q      <= '0;
         way_resolve_q <= '0;
         way_write_q   <= '0;
         way_inv_q     <= '0;
         way_vaddr_q   <= '0;
         way_enable_q  <= 1'b0;
         vaddr_w_q     <= '0;
         tag_w_q       <= '0;
         phys_w_q      <= '0;
         resp_valid_q  <= 1'b0;
         resp_miss_q   <= 1'b0;
         resp_multi_q  <= 1'b0;
         resp_tag_q    <= '0;
         resp_phys_q   <= '0;
         hit_cnt_q     <= '0;
         miss_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         victim_q      <= victim_d;
         way_resolve_q <= way_resolve_d;
         way_write_q   <= way_write_d;
         way_inv_q     <= way_inv_d;
         way_vaddr_q   <= way_vaddr_d;
         way_enable_q  <= way_enable_d;
         vaddr_w_q     <= vaddr_w_d;
         tag_w_q       <= tag_w_d;
         phys_w_q      <= phys_w_d;
         resp_valid_q  <= resp_valid_d;
         resp_miss_q   <= resp_miss_d;
         resp_multi_q  <= resp_multi_d;
         resp_tag_q    <= resp_tag_d;
         resp_phys_q   <= resp_phys_d;
         hit_cnt_q     <= hit_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
      end
   end

   assign ctrl_bus.cmd_ready       = (state_q == ST_IDLE);
   assign ctrl_bus.resp_valid      = resp_valid_q;
   assign ctrl_bus.resp_miss       = resp_miss_q;
   assign ctrl_bus.resp_multihit   = resp_multi_q;
   assign ctrl_bus.resp_accesstag  = resp_tag_q;
   assign ctrl_bus.resp_phys       = resp_phys_q;
   assign ctrl_bus.way_resolve     = way_resolve_q;
   assign ctrl_bus.way_write       = way_write_q;
   assign ctrl_bus.way_invalidate  = way_inv_q;
   assign ctrl_bus.way_vaddr       = way_vaddr_q;
   assign ctrl_bus.way_enable      = way_enable_q;
   assign ctrl_bus.way_vaddr_w     = vaddr_w_q;
   assign ctrl_bus.way_accesstag_w = tag_w_q;
   assign ctrl_bus.way_phys_w      = phys_w_q;
   assign ctrl_bus.hit_count       = hit_cnt_q;
   assign ctrl_bus.miss_count      = miss_cnt_q;
endmodule

// File: tb/tb_armleocpu_tlb_ctrl.sv
// Scoreboard bench for armleocpu_tlb_ctrl: expected responses are queued when a resolve is
// accepted and popped by a monitor when resp_valid pulses; counter width is narrowed to reach saturation.
module tb_armleocpu_tlb_ctrl;
   localparam int WAYS   = 2;
   localparam int PHYS_W = 22;
   localparam int CNT_W  = 8;
   localparam int SAT_N  = (1 << CNT_W) + 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   armleocpu_tlb_ctrl_if #(.WAYS(WAYS), .PHYS_W(PHYS_W), .CNT_W(CNT_W)) bus_if ();

   armleocpu_tlb_ctrl #(.WAYS(WAYS), .PHYS_W(PHYS_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctrl_bus (bus_if)
   );

   typedef struct {
      int unsigned       cyc;
      logic              miss;
      logic              multi;
      logic [7:0]        tag;
      logic [PHYS_W-1:0] phys;
   } resp_t;

   resp_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    n_resp = 0;
   int    exp_hit = 0;
   int    exp_miss = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      resp_t e;
      #1;
      if (bus_if.resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            n_resp++;
            $display("resp %0d @%0d: miss=%0b multi=%0b tag=%02h phys=%06h", n_resp, cyc,
                     bus_if.resp_miss, bus_if.resp_multihit, bus_if.resp_accesstag, bus_if.resp_phys);
            chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            chk("resp_miss", 64'(bus_if.resp_miss), 64'(e.miss));
            chk("resp_multihit", 64'(bus_if.resp_multihit), 64'(e.multi));
            chk("resp_accesstag", 64'(bus_if.resp_accesstag), 64'(e.tag));
            chk("resp_phys", 64'(bus_if.resp_phys), 64'(e.phys));
         end
      end
   end

   task automatic set_ways(input logic [1:0] done, input logic [1:0] miss,
                           input logic [7:0] tag1, input logic [7:0] tag0,
                           input logic [PHYS_W-1:0] ph1, input logic [PHYS_W-1:0] ph0);
      bus_if.way_done        = done;
      bus_if.way_miss        = miss;
      bus_if.way_accesstag_r = {tag1, tag0};
      bus_if.way_phys_r      = {ph1, ph0};
   endtask

   // kind: 0 resolve, 1 write, 2 invalidate. Returns at T+1 with the command dropped.
   task automatic send(input int kind, input logic [19:0] va, input logic en,
                       input logic [7:0] at, input logic [PHYS_W-1:0] ph, output int unsigned t);
      bit ok = 0;
      t = 0;
      bus_if.cmd_vaddr      = va;
      bus_if.cmd_enable     = en;
      bus_if.cmd_accesstag  = at;
      bus_if.cmd_phys       = ph;
      bus_if.cmd_resolve    = (kind == 0);
      bus_if.cmd_write      = (kind == 1);
      bus_if.cmd_invalidate = (kind == 2);
      for (int k = 0; k < 20; k++) begin
         if (bus_if.cmd_ready === 1'b1) begin
            t  = cyc;
            ok = 1;
            step();
            break;
         end
         step();
      end
      bus_if.cmd_resolve    = 1'b0;
      bus_if.cmd_write      = 1'b0;
      bus_if.cmd_invalidate = 1'b0;
      if (!ok) chk("cmd_accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic resolve(input logic [19:0] va, input logic en, input logic miss,
                          input logic multi, input logic [7:0] tag, input logic [PHYS_W-1:0] ph);
      int unsigned t;
      resp_t e;
      send(0, va, en, 8'h00, '0, t);
      e.cyc = t + 3; e.miss = miss; e.multi = multi; e.tag = tag; e.phys = ph;
      exp_q.push_back(e);
      chk("way_resolve", 64'(bus_if.way_resolve), 64'(2'b11));
      chk("way_vaddr", 64'(bus_if.way_vaddr), 64'(va));
      chk("way_enable", 64'(bus_if.way_enable), 64'(en));
      step();
      step();
      if (miss) exp_miss = (exp_miss < CNT_MAX) ? exp_miss + 1 : CNT_MAX;
      else      exp_hit  = (exp_hit  < CNT_MAX) ? exp_hit + 1  : CNT_MAX;
      chk("hit_count", 64'(bus_if.hit_count), 64'(exp_hit));
      chk("miss_count", 64'(bus_if.miss_count), 64'(exp_miss));
   endtask

   task automatic write(input logic [19:0] va, input logic [7:0] at,
                        input logic [PHYS_W-1:0] ph, input logic [1:0] exp_mask);
      int unsigned t;
      send(1, va, 1'b0, at, ph, t);
      $display("write @%0d: vaddr=%05h tag=%02h way_write=%02b", t, va, at, bus_if.way_write);
      chk("way_write", 64'(bus_if.way_write), 64'(exp_mask));
      chk("way_vaddr_w", 64'(bus_if.way_vaddr_w), 64'(va));
      chk("way_accesstag_w", 64'(bus_if.way_accesstag_w), 64'(at));
      chk("way_phys_w", 64'(bus_if.way_phys_w), 64'(ph));
      step();
      chk("write_ready_again", 64'(bus_if.cmd_ready), 64'(1));
   endtask

   task automatic check_reset();
      chk("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'(1));
      chk("rst_way_strobes", 64'({bus_if.way_resolve, bus_if.way_write, bus_if.way_invalidate}), 64'(0));
      chk("rst_way_vaddr", 64'({bus_if.way_vaddr, bus_if.way_enable}), 64'(0));
      chk("rst_way_w", 64'({bus_if.way_vaddr_w, bus_if.way_accesstag_w, bus_if.way_phys_w}), 64'(0));
      chk("rst_resp_flags", 64'({bus_if.resp_valid, bus_if.resp_miss, bus_if.resp_multihit}), 64'(0));
      chk("rst_resp_data", 64'({bus_if.resp_accesstag, bus_if.resp_phys}), 64'(0));
      chk("rst_counters", 64'({bus_if.hit_count, bus_if.miss_count}), 64'(0));
   endtask

   initial begin
      int unsigned t;
      resp_t e;
      bus_if.cmd_resolve = 1'b0; bus_if.cmd_write = 1'b0; bus_if.cmd_invalidate = 1'b0;
      bus_if.cmd_vaddr = '0; bus_if.cmd_enable = 1'b0; bus_if.cmd_accesstag = '0; bus_if.cmd_phys = '0;
      set_ways(2'b11, 2'b11, 8'h00, 8'h00, '0, '0);
      repeat (3) step();
      check_reset();
      rst_n = 1'b1;
      step();

      // Every way misses; phys/tag must be zeroed on a miss.
      set_ways(2'b11, 2'b11, 8'h99, 8'h77, 22'h00321, 22'h01234);
      resolve(20'h12345, 1'b1, 1'b1, 1'b0, 8'h00, '0);

      // Round-robin victim, advancing even for an invalid tag.
      write(20'h00A01, 8'h0F, 22'h2ABCD, 2'b01);
      write(20'h00A02, 8'h0E, 22'h1BCDE, 2'b10);
      write(20'h00A03, 8'h11, 22'h0CDEF, 2'b01);

      // Both ways hit: lowest index wins, multihit flagged.
      set_ways(2'b11, 2'b00, 8'h55, 8'h33, 22'h15555, 22'h0AAAA);
      resolve(20'h0BEEF, 1'b1, 1'b0, 1'b1, 8'h33, 22'h0AAAA);

      // Only way 1 hits.
      set_ways(2'b11, 2'b01, 8'h55, 8'h33, 22'h15555, 22'h0AAAA);
      resolve(20'h0CAFE, 1'b1, 1'b0, 1'b0, 8'h55, 22'h15555);

      // Way 0 not done while way 1 hits: treated as a miss.
      set_ways(2'b10, 2'b00, 8'h55, 8'h33, 22'h15555, 22'h0AAAA);
      resolve(20'h0D00D, 1'b1, 1'b1, 1'b0, 8'h00, '0);

      // Translation disabled: way 0 taken, multihit suppressed.
      set_ways(2'b11, 2'b00, 8'h55, 8'h33, 22'h15555, 22'h0AAAA);
      resolve(20'h00042, 1'b0, 1'b0, 1'b0, 8'h33, 22'h0AAAA);

      // Invalidate beats a simultaneous resolve; the held resolve follows two cycles later.
      set_ways(2'b11, 2'b11, 8'h00, 8'h00, '0, '0);
      bus_if.cmd_vaddr = 20'h54321; bus_if.cmd_enable = 1'b1;
      bus_if.cmd_invalidate = 1'b1; bus_if.cmd_resolve = 1'b1;
      t = cyc;
      chk("simul_ready", 64'(bus_if.cmd_ready), 64'(1));
      step();
      bus_if.cmd_invalidate = 1'b0;
      e.cyc = t + 5; e.miss = 1'b1; e.multi = 1'b0; e.tag = 8'h00; e.phys = '0;
      exp_q.push_back(e);
      $display("invalidate @%0d: way_invalidate=%02b", t, bus_if.way_invalidate);
      chk("simul_way_invalidate", 64'(bus_if.way_invalidate), 64'(2'b11));
      chk("simul_no_resolve_yet", 64'(bus_if.way_resolve), 64'(0));
      step();
      step();
      chk("simul_way_resolve_t3", 64'(bus_if.way_resolve), 64'(2'b11));
      bus_if.cmd_resolve = 1'b0;
      step();
      step();
      exp_miss++;
      chk("simul_miss_count", 64'(bus_if.miss_count), 64'(exp_miss));
      write(20'h00B00, 8'h01, 22'h00001, 2'b01);

      // Saturate the miss counter with back-to-back resolves.
      for (int i = 0; i < SAT_N; i++) resolve(20'(i), 1'b1, 1'b1, 1'b0, 8'h00, '0);
      chk("miss_saturated", 64'(bus_if.miss_count), 64'(CNT_MAX));
      chk("hit_kept", 64'(bus_if.hit_count), 64'(3));

      // Reset during WAIT: no response, everything back to reset values.
      send(0, 20'h0F00F, 1'b1, 8'h00, '0, t);
      step();
      rst_n = 1'b0;
      #1;
      check_reset();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_quiet", 64'({bus_if.resp_valid, bus_if.way_resolve, bus_if.way_write}), 64'(0));
      end
      check_reset();
      exp_hit = 0;
      exp_miss = 0;
      write(20'h00C00, 8'h01, 22'h00002, 2'b01);

      repeat (3) step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
